// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic valid/ready pipeline register with a one-entry skid buffer
// Ports:
//   CLK       clock, all state updates on rising edge
//   Reset     synchronous active-low reset
//   InValid   upstream word present on InData
//   InReady   stage can accept a word (registered, independent of OutReady/InValid)
//   InData    upstream data word
//   OutValid  OutData holds a valid word
//   OutReady  downstream accepts OutData
//   OutData   downstream data word (main register)
//   Flush     (only with PIPE_SKID_FLUSH_EN) synchronous active-high flush to EMPTY
module pipe_skid_stage #(
  parameter int Width = 32
) (
  input  logic             CLK,
  input  logic             Reset,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             Flush,
`endif
  input  logic             InValid,
  output logic             InReady,
  input  logic [Width-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [Width-1:0] OutData
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             flush;
  logic             in_xfer;
  logic             out_xfer;
`ifdef PIPE_SKID_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif
  assign InReady  = Reset && (state_q != FULL);
  assign OutValid = state_q != EMPTY;
  assign OutData  = main_q;
  assign in_xfer  = InValid && InReady;
  assign out_xfer = OutValid && OutReady;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        main_d  = in_xfer ? InData : main_q;
        state_d = in_xfer ? BUSY : EMPTY;
      end
      BUSY: begin
        main_d  = (in_xfer && out_xfer) ? InData : main_q;
        skid_d  = (in_xfer && !out_xfer) ? InData : skid_q;
        state_d = (in_xfer && !out_xfer) ? FULL : (!in_xfer && out_xfer) ? EMPTY : BUSY;
      end
      FULL: begin
        main_d  = out_xfer ? skid_q : main_q;
        state_d = out_xfer ? BUSY : FULL;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and scoreboarded checks of pipe_skid_stage
module tb_pipe_skid_stage;
  logic        CLK;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] InData;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
`ifdef PIPE_SKID_FLUSH_EN
  logic        Flush;
`endif
  int vectors;
  int errors;
  logic [31:0] q[$];
  pipe_skid_stage #(.Width(32)) dut (
    .CLK(CLK),
    .Reset(Reset),
`ifdef PIPE_SKID_FLUSH_EN
    .Flush(Flush),
`endif
    .InValid(InValid),
    .InReady(InReady),
    .InData(InData),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .OutData(OutData)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    vectors = 0;
    errors = 0;
    Reset = 1'b0;
    InValid = 1'b1;
    InData = 32'hDEADBEEF;
    OutReady = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    Flush = 1'b0;
`endif
    step();
    step();
    check("rst_ovalid", {31'd0, OutValid}, 32'd0);
    check("rst_iready", {31'd0, InReady}, 32'd0);
    check("rst_odata", OutData, 32'd0);
    Reset = 1'b1;
    InValid = 1'b0;
    #1;
    check("post_rst_iready", {31'd0, InReady}, 32'd1);
    check("post_rst_ovalid", {31'd0, OutValid}, 32'd0);
    OutReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      InValid = 1'b1;
      InData = i;
      step();
      check("stream_ovalid", {31'd0, OutValid}, 32'd1);
      check("stream_odata", OutData, i);
      check("stream_iready", {31'd0, InReady}, 32'd1);
    end
    InValid = 1'b0;
    step();
    check("stream_drain", {31'd0, OutValid}, 32'd0);
    OutReady = 1'b0;
    InValid = 1'b1;
    InData = 32'hA;
    step();
    InData = 32'hB;
    step();
    InValid = 1'b0;
    check("full_iready", {31'd0, InReady}, 32'd0);
    check("full_ovalid", {31'd0, OutValid}, 32'd1);
    check("full_odata", OutData, 32'hA);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_odata", OutData, 32'hA);
      check("stall_iready", {31'd0, InReady}, 32'd0);
    end
    OutReady = 1'b1;
    step();
    check("unstall_odata", OutData, 32'hB);
    check("unstall_iready", {31'd0, InReady}, 32'd1);
    step();
    check("unstall_empty", {31'd0, OutValid}, 32'd0);
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      logic iv, orr, er;
      logic [31:0] d;
      iv = 1'($urandom_range(0, 1));
      orr = 1'($urandom_range(0, 1));
      d = $urandom;
      er = q.size() < 2;
      InValid = iv;
      OutReady = orr;
      InData = d;
      #1;
      check("rnd_iready", {31'd0, InReady}, {31'd0, er});
      check("rnd_ovalid", {31'd0, OutValid}, {31'd0, q.size() > 0});
      if (q.size() > 0) check("rnd_odata", OutData, q[0]);
      if (q.size() > 0 && orr) void'(q.pop_front());
      if (iv && er) q.push_back(d);
      step();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    step();
    step();
    step();
    check("rnd_drained", {31'd0, OutValid}, 32'd0);
    OutReady = 1'b0;
    InValid = 1'b1;
    InData = 32'h11;
    step();
    InData = 32'h22;
    step();
    InValid = 1'b0;
    check("pre_rst_full", {31'd0, InReady}, 32'd0);
    Reset = 1'b0;
    step();
    check("midrst_ovalid", {31'd0, OutValid}, 32'd0);
    check("midrst_odata", OutData, 32'd0);
    Reset = 1'b1;
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_word", {31'd0, OutValid}, 32'd0);
    end
`ifdef PIPE_SKID_FLUSH_EN
    OutReady = 1'b0;
    InValid = 1'b1;
    InData = 32'h33;
    step();
    InData = 32'h44;
    step();
    InData = 32'h55;
    OutReady = 1'b1;
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    InValid = 1'b0;
    check("flush_full_ovalid", {31'd0, OutValid}, 32'd0);
    InValid = 1'b1;
    InData = 32'h66;
    step();
    InValid = 1'b0;
    check("after_flush_ovalid", {31'd0, OutValid}, 32'd1);
    check("after_flush_odata", OutData, 32'h66);
    step();
    check("after_flush_empty", {31'd0, OutValid}, 32'd0);
    OutReady = 1'b0;
    InValid = 1'b1;
    InData = 32'h77;
    step();
    InData = 32'h88;
    check("busy_iready", {31'd0, InReady}, 32'd1);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    InValid = 1'b0;
    check("flush_busy_ovalid", {31'd0, OutValid}, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
